cva6_cfg_discovery_reader: RTL

//  Read-only discovery port that serialises the elaborated cva6_cfg configuration into a fixed table of 64-bit words.
//  The configuration package is the producer; this block is the consumer/reader side.

---
 rtl/cva6_cfg_discovery_reader.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cva6_cfg_discovery_reader.sv
// Read-only discovery port: publishes the elaborated core configuration as a
// fixed 32-word table of 64-bit capability words behind a req/gnt/rvalid port.

package config_pkg;

   typedef enum logic [1:0] {
      WB       = 2'd0,
      WT       = 2'd1,
      HPDCACHE = 2'd2
   } cache_type_t;

   // Reduced configuration record holding only the fields this reader publishes.
   typedef struct packed {
      int unsigned       XLEN;
      bit                RVA;
      bit                RVB;
      bit                RVC;
      bit                RVF;
      bit                RVD;
      bit                RVH;
      bit                RVV;
      bit                RVZCB;
      bit                RVZCMP;
      bit                RVZiCond;
      bit                RVS;
      bit                RVU;
      bit                CvxifEn;
      bit                MmuPresent;
      bit                DebugEn;
      bit                PerfCounterEn;
      bit                FpgaEn;
      int unsigned       IcacheByteSize;
      int unsigned       IcacheLineWidth;
      int unsigned       IcacheSetAssoc;
      int unsigned       DcacheByteSize;
      int unsigned       DcacheLineWidth;
      int unsigned       DcacheSetAssoc;
      cache_type_t       DCacheType;
      int unsigned       NrScoreboardEntries;
      int unsigned       NrPMPEntries;
      int unsigned       RASDepth;
      int unsigned       BTBEntries;
      int unsigned       BHTEntries;
      int unsigned       NrExecuteRegionRules;
      int unsigned       NrCachedRegionRules;
      int unsigned       NrNonIdempotentRules;
      int unsigned       MaxOutstandingStores;
      logic [63:0]       HaltAddress;
      logic [63:0]       ExceptionAddress;
      logic [63:0]       DmBaseAddress;
      logic [7:0][63:0]  ExecuteRegionAddrBase;
      logic [7:0][63:0]  ExecuteRegionLength;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

module cva6_cfg_discovery_reader #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
   parameter int unsigned           IdxWidth = 6,
   parameter int unsigned           RspDepth = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic [IdxWidth-1:0] idx_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [63:0]         rdata_o,
   output logic                rerr_o,
   input  logic                rready_i,
   output logic [15:0]         nreads_o,
   output logic [7:0]          nerrs_o
);

   localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam int unsigned CntW = $clog2(RspDepth + 1);

   typedef logic [31:0][63:0] table_t;

   typedef struct packed {
      logic        err;
      logic [63:0] data;
   } rsp_t;

   function automatic table_t build_table();
      table_t t;
      t = '0;
      t[0] = 64'h4356_4136_0000_0001;
      t[1][7:0] = 8'(CVA6Cfg.XLEN);
      t[1][8]   = CVA6Cfg.RVA;
      t[1][9]   = CVA6Cfg.RVB;
      t[1][10]  = CVA6Cfg.RVC;
      t[1][11]  = CVA6Cfg.RVF;
      t[1][12]  = CVA6Cfg.RVD;
      t[1][13]  = CVA6Cfg.RVH;
      t[1][14]  = CVA6Cfg.RVV;
      t[1][15]  = CVA6Cfg.RVZCB;
      t[1][16]  = CVA6Cfg.RVZCMP;
      t[1][17]  = CVA6Cfg.RVZiCond;
      t[1][18]  = CVA6Cfg.RVS;
      t[1][19]  = CVA6Cfg.RVU;
      t[1][20]  = CVA6Cfg.CvxifEn;
      t[1][21]  = CVA6Cfg.MmuPresent;
      t[1][22]  = CVA6Cfg.DebugEn;
      t[1][23]  = CVA6Cfg.PerfCounterEn;
      t[1][24]  = CVA6Cfg.FpgaEn;
      t[2] = {8'd0, 8'(CVA6Cfg.IcacheSetAssoc), 16'(CVA6Cfg.IcacheLineWidth),
              32'(CVA6Cfg.IcacheByteSize)};
      t[3] = {6'd0, CVA6Cfg.DCacheType, 8'(CVA6Cfg.DcacheSetAssoc),
              16'(CVA6Cfg.DcacheLineWidth), 32'(CVA6Cfg.DcacheByteSize)};
      t[4] = {8'd0, 16'(CVA6Cfg.BHTEntries), 16'(CVA6Cfg.BTBEntries),
              8'(CVA6Cfg.RASDepth), 8'(CVA6Cfg.NrPMPEntries),
              8'(CVA6Cfg.NrScoreboardEntries)};
      t[5] = {32'd0, 8'(CVA6Cfg.MaxOutstandingStores), 8'(CVA6Cfg.NrNonIdempotentRules),
              8'(CVA6Cfg.NrCachedRegionRules), 8'(CVA6Cfg.NrExecuteRegionRules)};
      t[6] = CVA6Cfg.HaltAddress;
      t[7] = CVA6Cfg.ExceptionAddress;
      t[8] = CVA6Cfg.DmBaseAddress;
      // Region slots beyond the configured rule count stay zero even if the
      // underlying arrays hold leftover values.
      for (int unsigned k = 0; k < 8; k++) begin
         if (k < CVA6Cfg.NrExecuteRegionRules) begin
            t[5'(16 + 2 * k)] = CVA6Cfg.ExecuteRegionAddrBase[3'(k)];
            t[5'(17 + 2 * k)] = CVA6Cfg.ExecuteRegionLength[3'(k)];
         end
      end
      return t;
   endfunction

   localparam table_t Table = build_table();

   if (RspDepth < 1 || IdxWidth < 1 || IdxWidth > 32) begin : g_bad_params
      $error("cva6_cfg_discovery_reader: RspDepth must be >= 1 and IdxWidth in 1..32");
   end

   if (CVA6Cfg.XLEN > 255 || CVA6Cfg.IcacheLineWidth > 65535 ||
       CVA6Cfg.IcacheSetAssoc > 255 || CVA6Cfg.DcacheLineWidth > 65535 ||
       CVA6Cfg.DcacheSetAssoc > 255 || CVA6Cfg.NrScoreboardEntries > 255 ||
       CVA6Cfg.NrPMPEntries > 255 || CVA6Cfg.RASDepth > 255 ||
       CVA6Cfg.BTBEntries > 65535 || CVA6Cfg.BHTEntries > 65535 ||
       CVA6Cfg.NrExecuteRegionRules > 8 || CVA6Cfg.NrCachedRegionRules > 255 ||
       CVA6Cfg.NrNonIdempotentRules > 255 || CVA6Cfg.MaxOutstandingStores > 255)
   begin : g_cfg_overflow
      $error("cva6_cfg_discovery_reader: configuration value overflows its table slot");
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(RspDepth - 1)) ? '0 : p + 1'b1;
   endfunction

   rsp_t            mem_q [RspDepth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [15:0]     nreads_q, nreads_d;
   logic [7:0]      nerrs_q, nerrs_d;

   logic [31:0] idx_ext;
   logic        idx_err;
   logic        push;
   logic        pop;
   rsp_t        rsp_new;

   assign idx_ext = 32'(idx_i);
   assign idx_err = (idx_ext > 32'd31);

   // Occupancy at the start of the cycle gates the grant; a same-cycle pop
   // does not open a slot, which keeps gnt_o off the rready_i path.
   assign push = req_i && (count_q < CntW'(RspDepth));
   assign pop  = (count_q != '0) && rready_i;

   always_comb begin
      rsp_new      = '0;
      rsp_new.err  = idx_err;
      rsp_new.data = idx_err ? 64'd0 : Table[idx_ext[4:0]];
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      nreads_d = nreads_q;
      nerrs_d  = nerrs_q;
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      if (push && nreads_q != 16'hFFFF) begin
         nreads_d = nreads_q + 16'd1;
      end
      if (push && idx_err && nerrs_q != 8'hFF) begin
         nerrs_d = nerrs_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         nreads_q <= '0;
         nerrs_q  <= '0;
         for (int unsigned i = 0; i < RspDepth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         nreads_q <= nreads_d;
         nerrs_q  <= nerrs_d;
         if (push) begin
            mem_q[wr_ptr_q] <= rsp_new;
         end
      end
   end

   assign gnt_o    = push;
   assign rvalid_o = (count_q != '0);
   assign rdata_o  = rvalid_o ? mem_q[rd_ptr_q].data : 64'd0;
   assign rerr_o   = rvalid_o ? mem_q[rd_ptr_q].err : 1'b0;
   assign nreads_o = nreads_q;
   assign nerrs_o  = nerrs_q;

endmodule
